fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the single PC register and the F/D pipeline registers with a PC generator, a one-outstanding-request instruction-memory handshake and a DEPTH-entry prefetch queue. Fetch is therefore decoupled from decode stalls. Decode-stage branch/jump redirects flush the queue and discard any in-flight fetch.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [0:0] {
    Run,
    Discard
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous clear that overrides push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Empty queue presents zeros, like a bubble in the old F/D register.
  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding imem handshake
// and a prefetch queue that decouples fetch from decode stalls.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [INSTR_W-1:0] instr_d_o,
  output logic [XLEN-1:0]    pcplus4_d_o
);

  localparam int unsigned EntryW = XLEN + INSTR_W;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
  logic [XLEN-1:0]   pc_plus4;
  logic [CntW-1:0]   count;
  logic [EntryW-1:0] head;
  logic              ack, push, pop, clr;

  assign pc_plus4    = fetch_pc_q + XLEN'(PC_STEP);
  assign imem_req_o  = rst_ni & ((state_q == Discard) | (count < CntW'(DEPTH)));
  assign imem_addr_o = (state_q == Discard) ? hold_addr_q : fetch_pc_q;
  assign ack         = imem_req_o & imem_ack_i;
  assign dec_valid_o = (count != '0);
  assign pop         = dec_valid_o & dec_ready_i;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    push        = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      Run: begin
        if (redirect_i) begin
          clr        = 1'b1;
          fetch_pc_d = redirect_pc_i;
          // A still-pending request must complete before the new target is fetched.
          if (imem_req_o && !imem_ack_i) begin
            hold_addr_d = imem_addr_o;
            state_d     = Discard;
          end
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
        end
      end
      Discard: begin
        if (redirect_i) begin
          clr        = 1'b1;
          fetch_pc_d = redirect_pc_i;
        end
        if (ack) state_d = Run;
      end
      default: state_d = Run;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Run;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i ({pc_plus4, imem_rdata_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign pcplus4_d_o = head[EntryW-1:INSTR_W];
  assign instr_d_o   = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: queue-based reference model plus a scoreboard monitor.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] instr_d, pcplus4_d;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .instr_d_o     (instr_d),
    .pcplus4_d_o   (pcplus4_d)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: the scoreboard queue doubles as the prefetch queue contents.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;
  entry_t      sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_hold;
  bit          m_discard;
  bit          mem_pending;
  int          mem_waits;

  // Inputs driven in the previous cycle, applied to the model at the next negedge.
  bit          sv_valid;
  bit          sv_req, sv_ack, sv_redir;
  logic [31:0] sv_addr, sv_rpc;

  int ready_pct = 100;
  int redir_pct = 0;
  int max_wait  = 0;

  task automatic model_reset();
    sb.delete();
    m_pc        = RESET_PC;
    m_hold      = '0;
    m_discard   = 0;
    mem_pending = 0;
    mem_waits   = 0;
    sv_valid    = 0;
  endtask

  task automatic model_step();
    if (!m_discard) begin
      if (sv_redir) begin
        sb.delete();
        if (sv_req && !sv_ack) begin
          m_hold    = sv_addr;
          m_discard = 1;
        end
        m_pc = sv_rpc;
      end else if (sv_ack) begin
        sb.push_back('{pc4: m_pc + 32'd4, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (sv_redir) begin
        sb.delete();
        m_pc = sv_rpc;
      end
      if (sv_ack) m_discard = 0;
    end
  endtask

  task automatic cycle();
    bit          m_req, a;
    logic [31:0] m_addr;
    @(negedge clk);
    if (sv_valid) model_step();
    m_req  = m_discard || (sb.size() < DEPTH);
    m_addr = m_discard ? m_hold : m_pc;
    chk("imem_req", 64'(imem_req), 64'(m_req));
    if (m_req) chk("imem_addr", 64'(imem_addr), 64'(m_addr));
    a = 0;
    if (m_req) begin
      if (!mem_pending) begin
        mem_pending = 1;
        mem_waits   = $urandom_range(max_wait, 0);
      end
      if (mem_waits == 0) begin
        a           = 1;
        mem_pending = 0;
      end else begin
        mem_waits--;
      end
    end
    imem_ack   = a;
    imem_rdata = a ? mem_word(m_addr) : $urandom();
    dec_ready  = ($urandom_range(99, 0) < ready_pct);
    redirect   = ($urandom_range(99, 0) < redir_pct);
    case ($urandom_range(2, 0))
      0:       redirect_pc = 32'h0000_0100;
      1:       redirect_pc = 32'hFFFF_FFF8;
      default: redirect_pc = $urandom() & 32'hFFFF_FFFC;
    endcase
    sv_req   = m_req;
    sv_addr  = m_addr;
    sv_ack   = a;
    sv_redir = redirect;
    sv_rpc   = redirect_pc;
    sv_valid = 1;
  endtask

  // Monitor: compares the head of decode against the scoreboard whenever a pop happens.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("dec_valid", 64'(dec_valid), 64'(sb.size() != 0));
        if (sb.size() != 0 && dec_ready) begin
          e = sb.pop_front();
          chk("instrD", 64'(instr_d), 64'(e.instr));
          chk("pcplus4D", 64'(pcplus4_d), 64'(e.pc4));
        end else if (sb.size() == 0) begin
          chk("instrD_empty", 64'(instr_d), 64'h0);
          chk("pcplus4D_empty", 64'(pcplus4_d), 64'h0);
        end
      end
    end
  end

  task automatic run(input int n, input int rdy, input int rd, input int mw);
    ready_pct = rdy;
    redir_pct = rd;
    max_wait  = mw;
    repeat (n) cycle();
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    model_reset();
    #3;
    chk("rst_imem_req", 64'(imem_req), 64'h0);
    chk("rst_dec_valid", 64'(dec_valid), 64'h0);
    chk("rst_instrD", 64'(instr_d), 64'h0);
    chk("rst_pcplus4D", 64'(pcplus4_d), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(30, 100, 0, 0);   // streaming, one instruction per cycle
    run(12, 0, 0, 1);     // decode stalled: queue fills and fetch stops
    run(10, 100, 0, 0);   // drain in order, fetch resumes
    run(600, 70, 8, 3);   // redirects against pending requests
    run(400, 50, 15, 0);  // redirects with zero-wait memory, incl. same-cycle ack
    run(200, 100, 5, 1);  // wrap past 0xFFFFFFFC via redirect targets

    // Reset asserted mid-request with entries queued.
    run(6, 0, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dec_valid", 64'(dec_valid), 64'h0);
    chk("midrst_imem_req", 64'(imem_req), 64'h0);
    chk("midrst_instrD", 64'(instr_d), 64'h0);
    model_reset();
    imem_ack  = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(60, 80, 3, 2);

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
